control_sequencer: RTL

//  Microcoded T-state sequencer that drives the 8-bit bus machine. Consumes the
//  4-bit opcode from the instruction register plus ALU flags; emits the control

---
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer for the 8-bit bus machine.
// The stage register and the HLT freeze flag are the only state. The control
// word is a combinational decode of (stage, opcode, flags).
module control_sequencer #(
    parameter bit NOP_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] control,
    output logic [2:0]  stage,
    output logic        halted
);

    localparam int unsigned CW = 16;
    localparam int unsigned SW = 3;

    // Control word bit masks (active-low strobes are cleared from the idle word)
    localparam logic [CW-1:0] IDLE_WORD   = 16'h7F76;
    localparam logic [CW-1:0] M_HLT       = 16'h8000;
    localparam logic [CW-1:0] M_MAR_LOAD  = 16'h4000;
    localparam logic [CW-1:0] M_RAM_EN    = 16'h2000;
    localparam logic [CW-1:0] M_RAM_LOAD  = 16'h1000;
    localparam logic [CW-1:0] M_IR_LOAD   = 16'h0800;
    localparam logic [CW-1:0] M_IR_EN     = 16'h0400;
    localparam logic [CW-1:0] M_A_LOAD    = 16'h0200;
    localparam logic [CW-1:0] M_A_EN      = 16'h0100;
    localparam logic [CW-1:0] M_SUB       = 16'h0080;
    localparam logic [CW-1:0] M_ALU_EN    = 16'h0040;
    localparam logic [CW-1:0] M_B_LOAD    = 16'h0020;
    localparam logic [CW-1:0] M_OUT_LOAD  = 16'h0010;
    localparam logic [CW-1:0] M_PC_INC    = 16'h0008;
    localparam logic [CW-1:0] M_PC_EN     = 16'h0004;
    localparam logic [CW-1:0] M_PC_LOAD   = 16'h0002;
    localparam logic [CW-1:0] M_FLAGS     = 16'h0001;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [SW-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } stage_t;

    stage_t          r_stage;
    stage_t          w_stage_nxt;
    logic            r_halted;
    logic            w_halted_nxt;
    stage_t          w_last;
    logic [CW-1:0]   w_low;
    logic [CW-1:0]   w_high;
    logic [CW-1:0]   w_ctrl;

    // Stage and halt state registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_stage  <= T0;
            r_halted <= 1'b0;
        end else begin
            r_stage  <= w_stage_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Last active stage of each opcode, used when NOP_SKIP shortens the cycle
    always_comb begin
        w_last = T1;
        unique case (opcode)
            OP_LDA, OP_STA:                         w_last = T3;
            OP_ADD, OP_SUB:                         w_last = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                 w_last = T2;
            default:                                w_last = T1;
        endcase
    end

    // Next-state logic: advance, wrap, freeze on HLT, recover from illegal codes
    always_comb begin
        w_stage_nxt  = T0;
        w_halted_nxt = r_halted;
        if (r_halted) begin
            w_stage_nxt = r_stage;
        end else begin
            unique case (r_stage)
                T0, T1, T2, T3, T4: begin
                    if (r_stage == T2 && opcode == OP_HLT) begin
                        w_stage_nxt  = T2;
                        w_halted_nxt = 1'b1;
                    end else if ((NOP_SKIP && r_stage == w_last) || r_stage == T4) begin
                        w_stage_nxt = T0;
                    end else begin
                        w_stage_nxt = stage_t'(SW'(r_stage) + SW'(1));
                    end
                end
                default: w_stage_nxt = T0;
            endcase
        end
    end

    // Control word decode: w_low lists asserted active-low strobes, w_high active-high bits
    always_comb begin
        w_low  = '0;
        w_high = '0;
        if (r_halted) begin
            w_high = M_HLT;
        end else begin
            unique case (r_stage)
                T0: w_low = M_PC_EN | M_MAR_LOAD;
                T1: begin
                    w_low  = M_RAM_EN | M_IR_LOAD;
                    w_high = M_PC_INC;
                end
                T2: begin
                    unique case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: w_low = M_IR_EN | M_MAR_LOAD;
                        OP_LDI:  w_low = M_IR_EN | M_A_LOAD;
                        OP_JMP:  w_low = M_IR_EN | M_PC_LOAD;
                        OP_JC:   w_low = carry_flag ? (M_IR_EN | M_PC_LOAD) : '0;
                        OP_JZ:   w_low = zero_flag  ? (M_IR_EN | M_PC_LOAD) : '0;
                        OP_OUT:  w_low = M_A_EN | M_OUT_LOAD;
                        OP_HLT:  w_high = M_HLT;
                        default: w_low = '0;
                    endcase
                end
                T3: begin
                    unique case (opcode)
                        OP_LDA:         w_low = M_RAM_EN | M_A_LOAD;
                        OP_ADD, OP_SUB: w_low = M_RAM_EN | M_B_LOAD;
                        OP_STA:         w_low = M_A_EN | M_RAM_LOAD;
                        default:        w_low = '0;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_low  = M_ALU_EN | M_A_LOAD;
                        w_high = M_FLAGS | ((opcode == OP_SUB) ? M_SUB : '0);
                    end
                end
                default: begin
                    w_low  = '0;
                    w_high = '0;
                end
            endcase
        end
        w_ctrl = (IDLE_WORD & ~w_low) | w_high;
    end

    // Outputs; clear forces the idle word without waiting for a clock
    always_comb begin
        control = clear ? IDLE_WORD : w_ctrl;
        stage   = SW'(r_stage);
        halted  = r_halted;
    end

endmodule
